// File: rtl/ram_wb_buffer_pkg.sv
// Shared state encoding and counter width for the RAM write-back buffer.
package ram_wb_buffer_pkg;

    typedef enum logic [1:0] {
        RAM_WB_FSM_IDLE  = 2'b00,
        RAM_WB_FSM_RECV  = 2'b01,
        RAM_WB_FSM_DRAIN = 2'b10
    } ram_wb_state_e;

    localparam int RAM_WB_CNT_W = 4;

endpackage

// File: rtl/ram_wb_fifo.sv
// Row FIFO between the MXU result stream and the RAM write port.
module ram_wb_fifo #(
    parameter int ENT_NUM   = 4,
    parameter int RAM_WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [RAM_WIDTH-1:0] din,
    output logic [RAM_WIDTH-1:0] dout,
    output logic                 full,
    output logic                 empty
);

    localparam int PTR_W = $clog2(ENT_NUM);

    logic [RAM_WIDTH-1:0] mem_q [ENT_NUM];
    logic [PTR_W:0]       wr_ptr_q;
    logic [PTR_W:0]       rd_ptr_q;

    // Extra MSB on each pointer separates full from empty when indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign dout  = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/ram_wb_buffer.sv
// Collects MXU result rows and writes them to RAM at start_addr +/- row offset,
// trimming the first and last rows with byte strobes.
module ram_wb_buffer
    import ram_wb_buffer_pkg::*;
#(
    parameter int ENT_NUM    = 4,
    parameter int RAM_WIDTH  = 128,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ctrl_ram_wb_vld,
    input  logic [ADDR_WIDTH-1:0]   ctrl_ram_wb_start_addr,
    input  logic [3:0]              ctrl_ram_wb_ent_num,
    input  logic                    ctrl_ram_wb_dir,
    input  logic [3:0]              ctrl_ram_wb_start_byte,
    input  logic [3:0]              ctrl_ram_wb_end_byte,
    input  logic                    mxu_ram_wb_vld,
    input  logic [RAM_WIDTH-1:0]    mxu_ram_wb_data,
    output logic                    ram_wb_mxu_rdy,
    output logic                    ram_write_vld,
    output logic [ADDR_WIDTH-1:0]   ram_write_addr,
    output logic [RAM_WIDTH-1:0]    ram_write_data,
    output logic [RAM_WIDTH/8-1:0]  ram_write_strb,
    input  logic                    ram_write_rdy,
    output logic                    ram_wb_busy,
    output logic                    ram_wb_done
);

    localparam int         STRB_W    = RAM_WIDTH / 8;
    localparam logic [3:0] LAST_BYTE = 4'(STRB_W - 1);

    ram_wb_state_e             state_q;
    logic [ADDR_WIDTH-1:0]     start_addr_q;
    logic [ADDR_WIDTH-1:0]     offset_q;
    logic [ADDR_WIDTH-1:0]     offset_d;
    logic [RAM_WB_CNT_W-1:0]   ent_num_q;
    logic [RAM_WB_CNT_W-1:0]   recv_cnt_q;
    logic [RAM_WB_CNT_W-1:0]   wr_cnt_q;
    logic [3:0]                start_byte_q;
    logic [3:0]                end_byte_q;
    logic                      dir_q;

    logic                      fifo_full;
    logic                      fifo_empty;
    logic [RAM_WIDTH-1:0]      fifo_dout;
    logic                      push;
    logic                      pop;
    logic                      last_push;
    logic                      last_pop;
    logic [STRB_W-1:0]         strb_first;
    logic [STRB_W-1:0]         strb_last;
    logic [STRB_W-1:0]         strb_row;

    ram_wb_fifo #(
        .ENT_NUM   (ENT_NUM),
        .RAM_WIDTH (RAM_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (mxu_ram_wb_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ram_wb_mxu_rdy = (state_q == RAM_WB_FSM_RECV) & ~fifo_full;
    assign ram_write_vld  = ~fifo_empty & (state_q != RAM_WB_FSM_IDLE);
    assign push           = mxu_ram_wb_vld & ram_wb_mxu_rdy;
    assign pop            = ram_write_vld & ram_write_rdy;
    assign last_push      = push & (recv_cnt_q == ent_num_q);
    assign last_pop       = pop & (wr_cnt_q == ent_num_q);
    assign offset_d       = dir_q ? (offset_q - ADDR_WIDTH'(1)) : (offset_q + ADDR_WIDTH'(1));

    // A single-row transfer gets both masks; start_byte > end_byte yields zero.
    assign strb_first = {STRB_W{1'b1}} << start_byte_q;
    assign strb_last  = {STRB_W{1'b1}} >> (LAST_BYTE - end_byte_q);

    always_comb begin
        strb_row = {STRB_W{1'b1}};
        if (wr_cnt_q == '0) begin
            strb_row = strb_row & strb_first;
        end
        if (wr_cnt_q == ent_num_q) begin
            strb_row = strb_row & strb_last;
        end
    end

    // Write-side outputs read as zero whenever no write is being offered.
    assign ram_write_addr = ram_write_vld ? (start_addr_q + offset_q) : '0;
    assign ram_write_data = ram_write_vld ? fifo_dout : '0;
    assign ram_write_strb = ram_write_vld ? strb_row : '0;
    assign ram_wb_busy    = (state_q != RAM_WB_FSM_IDLE);
    assign ram_wb_done    = last_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RAM_WB_FSM_IDLE;
            start_addr_q <= '0;
            offset_q     <= '0;
            ent_num_q    <= '0;
            recv_cnt_q   <= '0;
            wr_cnt_q     <= '0;
            start_byte_q <= '0;
            end_byte_q   <= '0;
            dir_q        <= 1'b0;
        end else begin
            if (push) begin
                recv_cnt_q <= recv_cnt_q + RAM_WB_CNT_W'(1);
            end
            if (pop) begin
                wr_cnt_q <= wr_cnt_q + RAM_WB_CNT_W'(1);
                offset_q <= offset_d;
            end
            case (state_q)
                RAM_WB_FSM_IDLE: begin
                    if (ctrl_ram_wb_vld) begin
                        start_addr_q <= ctrl_ram_wb_start_addr;
                        ent_num_q    <= ctrl_ram_wb_ent_num;
                        dir_q        <= ctrl_ram_wb_dir;
                        start_byte_q <= ctrl_ram_wb_start_byte;
                        end_byte_q   <= ctrl_ram_wb_end_byte;
                        recv_cnt_q   <= '0;
                        wr_cnt_q     <= '0;
                        offset_q     <= '0;
                        state_q      <= RAM_WB_FSM_RECV;
                    end
                end
                RAM_WB_FSM_RECV: begin
                    if (last_push && last_pop) begin
                        state_q <= RAM_WB_FSM_IDLE;
                    end else if (last_push) begin
                        state_q <= RAM_WB_FSM_DRAIN;
                    end
                end
                RAM_WB_FSM_DRAIN: begin
                    if (last_pop) begin
                        state_q <= RAM_WB_FSM_IDLE;
                    end
                end
                default: state_q <= RAM_WB_FSM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_wb_buffer.sv
// Directed bench for ram_wb_buffer: a queue-based transfer model checked every cycle,
// plus literal expectations for addresses, strobes and done pulses per scenario.
module tb_ram_wb_buffer;

    localparam int ENT = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ctrl_ram_wb_vld = 1'b0;
    logic [7:0]   ctrl_ram_wb_start_addr = '0;
    logic [3:0]   ctrl_ram_wb_ent_num = '0;
    logic         ctrl_ram_wb_dir = 1'b0;
    logic [3:0]   ctrl_ram_wb_start_byte = '0;
    logic [3:0]   ctrl_ram_wb_end_byte = '0;
    logic         mxu_ram_wb_vld = 1'b0;
    logic [127:0] mxu_ram_wb_data = '0;
    logic         ram_wb_mxu_rdy;
    logic         ram_write_vld;
    logic [7:0]   ram_write_addr;
    logic [127:0] ram_write_data;
    logic [15:0]  ram_write_strb;
    logic         ram_write_rdy = 1'b0;
    logic         ram_wb_busy;
    logic         ram_wb_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_wb_buffer #(.ENT_NUM(ENT), .RAM_WIDTH(128), .ADDR_WIDTH(8)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .ctrl_ram_wb_vld        (ctrl_ram_wb_vld),
        .ctrl_ram_wb_start_addr (ctrl_ram_wb_start_addr),
        .ctrl_ram_wb_ent_num    (ctrl_ram_wb_ent_num),
        .ctrl_ram_wb_dir        (ctrl_ram_wb_dir),
        .ctrl_ram_wb_start_byte (ctrl_ram_wb_start_byte),
        .ctrl_ram_wb_end_byte   (ctrl_ram_wb_end_byte),
        .mxu_ram_wb_vld         (mxu_ram_wb_vld),
        .mxu_ram_wb_data        (mxu_ram_wb_data),
        .ram_wb_mxu_rdy         (ram_wb_mxu_rdy),
        .ram_write_vld          (ram_write_vld),
        .ram_write_addr         (ram_write_addr),
        .ram_write_data         (ram_write_data),
        .ram_write_strb         (ram_write_strb),
        .ram_write_rdy          (ram_write_rdy),
        .ram_wb_busy            (ram_wb_busy),
        .ram_wb_done            (ram_wb_done)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mstrb(input int k, input int en, input int sb, input int eb);
        logic [15:0] s;
        for (int i = 0; i < 16; i++) begin
            s[i] = ((k != 0) || (i >= sb)) && ((k != en) || (i <= eb));
        end
        return s;
    endfunction

    function automatic logic [127:0] row_data(input logic [31:0] seed, input int i);
        return {seed, 32'(i), ~seed, seed ^ 32'(i * 7 + 1)};
    endfunction

    // Transfer model: a command, a queue of accepted rows, and push/pop counts.
    bit           m_busy = 0;
    int           m_sa = 0, m_en = 0, m_dir = 0, m_sb = 0, m_eb = 0;
    int           m_pushed = 0, m_popped = 0;
    logic [127:0] m_fifo[$];

    logic [7:0]   lg_addr[$];
    logic [15:0]  lg_strb[$];
    logic [127:0] lg_data[$];
    int           lg_done = 0;

    initial begin : model
        bit           d_cmd, d_push, d_pop;
        bit           e_rdy, e_vld, e_done;
        logic [7:0]   e_addr;
        logic [15:0]  e_strb;
        logic [127:0] e_data, d_data;
        int           c_sa, c_en, c_dir, c_sb, c_eb;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (rst) begin
                m_busy = 0;
                m_fifo.delete();
                m_pushed = 0;
                m_popped = 0;
            end
            e_rdy  = m_busy && (m_pushed <= m_en) && (m_fifo.size() < ENT);
            e_vld  = m_busy && (m_fifo.size() > 0);
            e_addr = e_vld ? 8'(m_sa + (m_dir != 0 ? -m_popped : m_popped)) : 8'h00;
            e_data = e_vld ? m_fifo[0] : 128'h0;
            e_strb = e_vld ? mstrb(m_popped, m_en, m_sb, m_eb) : 16'h0;
            e_done = e_vld && ram_write_rdy && (m_popped == m_en);
            chk("mxu_rdy", ram_wb_mxu_rdy, e_rdy);
            chk("wr_vld", ram_write_vld, e_vld);
            chk("wr_addr", ram_write_addr, e_addr);
            chk("wr_data", ram_write_data, e_data);
            chk("wr_strb", ram_write_strb, e_strb);
            chk("busy", ram_wb_busy, m_busy);
            chk("done", ram_wb_done, e_done);
            if (ram_write_vld && ram_write_rdy) begin
                lg_addr.push_back(ram_write_addr);
                lg_strb.push_back(ram_write_strb);
                lg_data.push_back(ram_write_data);
            end
            if (ram_wb_done) lg_done++;
            d_cmd  = !rst && !m_busy && ctrl_ram_wb_vld;
            d_push = !rst && mxu_ram_wb_vld && e_rdy;
            d_pop  = !rst && e_vld && ram_write_rdy;
            d_data = mxu_ram_wb_data;
            c_sa = int'(ctrl_ram_wb_start_addr);
            c_en = int'(ctrl_ram_wb_ent_num);
            c_dir = int'(ctrl_ram_wb_dir);
            c_sb = int'(ctrl_ram_wb_start_byte);
            c_eb = int'(ctrl_ram_wb_end_byte);
            @(posedge clk);
            if (d_cmd) begin
                m_busy = 1;
                m_sa = c_sa; m_en = c_en; m_dir = c_dir; m_sb = c_sb; m_eb = c_eb;
                m_pushed = 0;
                m_popped = 0;
                m_fifo.delete();
            end else begin
                if (d_pop) begin
                    void'(m_fifo.pop_front());
                    m_popped++;
                end
                if (d_push) begin
                    m_fifo.push_back(d_data);
                    m_pushed++;
                end
                if (d_pop && (m_popped == m_en + 1)) m_busy = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        lg_addr.delete();
        lg_strb.delete();
        lg_data.delete();
        lg_done = 0;
    endtask

    task automatic cmd(input logic [7:0] sa, input logic [3:0] en, input logic dir,
                       input logic [3:0] sb, input logic [3:0] eb);
        ctrl_ram_wb_vld        = 1'b1;
        ctrl_ram_wb_start_addr = sa;
        ctrl_ram_wb_ent_num    = en;
        ctrl_ram_wb_dir        = dir;
        ctrl_ram_wb_start_byte = sb;
        ctrl_ram_wb_end_byte   = eb;
        tick();
        ctrl_ram_wb_vld = 1'b0;
    endtask

    task automatic stream(input int n, input logic [31:0] seed);
        int  i = 0;
        int  guard = 0;
        bit  acc;
        while (i < n && guard < 300) begin
            mxu_ram_wb_vld  = 1'b1;
            mxu_ram_wb_data = row_data(seed, i);
            @(negedge clk);
            acc = ram_wb_mxu_rdy;
            tick();
            if (acc) i++;
            guard++;
        end
        mxu_ram_wb_vld  = 1'b0;
        mxu_ram_wb_data = '0;
        chk("stream_rows_accepted", i, n);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (ram_wb_busy && n < max) begin
            tick();
            n++;
        end
        chk("idle_timeout", ram_wb_busy, 1'b0);
        tick();
    endtask

    logic [7:0]  t1_addr[4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    logic [15:0] t1_strb[4] = '{16'hFFFC, 16'hFFFF, 16'hFFFF, 16'h3FFF};
    logic [7:0]  t2_addr[5] = '{8'h02, 8'h01, 8'h00, 8'hFF, 8'hFE};

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        repeat (3) tick();
        chk("rst_vld", ram_write_vld, 1'b0);
        chk("rst_busy", ram_wb_busy, 1'b0);
        chk("rst_mxu_rdy", ram_wb_mxu_rdy, 1'b0);
        chk("rst_addr", ram_write_addr, 8'h00);
        chk("rst_strb", ram_write_strb, 16'h0000);
        rst = 1'b0;
        tick();

        // Ascending, trimmed first/last rows, back-to-back rows.
        clear_logs();
        ram_write_rdy = 1'b1;
        cmd(8'h10, 4'd3, 1'b0, 4'd2, 4'd13);
        stream(4, 32'h0000_1000);
        wait_idle(40);
        chk("t1_writes", lg_addr.size(), 4);
        for (int k = 0; k < 4 && k < lg_addr.size(); k++) begin
            chk("t1_addr", lg_addr[k], t1_addr[k]);
            chk("t1_strb", lg_strb[k], t1_strb[k]);
        end
        chk("t1_done_pulses", lg_done, 1);

        // Descending with wrap below zero.
        clear_logs();
        cmd(8'h02, 4'd4, 1'b1, 4'd0, 4'd15);
        stream(5, 32'h0000_2000);
        wait_idle(40);
        chk("t2_writes", lg_addr.size(), 5);
        for (int k = 0; k < 5 && k < lg_addr.size(); k++) begin
            chk("t2_addr", lg_addr[k], t2_addr[k]);
        end

        // Back-pressure on the RAM side fills the FIFO, then resumes in order.
        clear_logs();
        ram_write_rdy = 1'b0;
        cmd(8'h30, 4'd7, 1'b0, 4'd0, 4'd15);
        fork
            stream(8, 32'h0000_3000);
            begin
                repeat (10) @(posedge clk);
                #1;
                chk("t3_stall_mxu_rdy", ram_wb_mxu_rdy, 1'b0);
                chk("t3_stall_addr", ram_write_addr, 8'h30);
                chk("t3_stall_data", ram_write_data, row_data(32'h0000_3000, 0));
                ram_write_rdy = 1'b1;
            end
        join
        wait_idle(60);
        chk("t3_writes", lg_addr.size(), 8);
        for (int k = 0; k < 8 && k < lg_addr.size(); k++) begin
            chk("t3_addr", lg_addr[k], 8'(8'h30 + k));
            chk("t3_data", lg_data[k], row_data(32'h0000_3000, k));
        end

        // Single row; a second command while busy must be ignored.
        clear_logs();
        cmd(8'hA0, 4'd0, 1'b0, 4'd5, 4'd9);
        fork
            stream(1, 32'h0000_4000);
            begin
                ctrl_ram_wb_vld        = 1'b1;
                ctrl_ram_wb_start_addr = 8'h77;
                ctrl_ram_wb_ent_num    = 4'd2;
                tick();
                tick();
                ctrl_ram_wb_vld = 1'b0;
            end
        join
        wait_idle(20);
        repeat (4) tick();
        chk("t4_busy_after", ram_wb_busy, 1'b0);
        chk("t4_writes", lg_addr.size(), 1);
        if (lg_addr.size() > 0) begin
            chk("t4_addr", lg_addr[0], 8'hA0);
            chk("t4_strb", lg_strb[0], 16'h03E0);
        end
        chk("t4_done_pulses", lg_done, 1);

        // Single row with start_byte > end_byte: write issued with empty strobe.
        clear_logs();
        cmd(8'h50, 4'd0, 1'b0, 4'd9, 4'd5);
        stream(1, 32'h0000_5000);
        wait_idle(20);
        chk("t4b_writes", lg_addr.size(), 1);
        if (lg_strb.size() > 0) chk("t4b_strb", lg_strb[0], 16'h0000);
        chk("t4b_done_pulses", lg_done, 1);

        // Reset mid-DRAIN after two writes, then a fresh transfer.
        clear_logs();
        ram_write_rdy = 1'b0;
        cmd(8'h40, 4'd5, 1'b0, 4'd0, 4'd15);
        fork
            stream(6, 32'h0000_6000);
            begin
                repeat (6) @(posedge clk);
                #1;
                ram_write_rdy = 1'b1;
                @(posedge clk);
                @(posedge clk);
                #1;
                ram_write_rdy = 1'b0;
            end
        join
        chk("t5_busy_before_rst", ram_wb_busy, 1'b1);
        chk("t5_writes_before_rst", lg_addr.size(), 2);
        rst = 1'b1;
        #1;
        chk("t5_rst_vld", ram_write_vld, 1'b0);
        chk("t5_rst_busy", ram_wb_busy, 1'b0);
        chk("t5_rst_addr", ram_write_addr, 8'h00);
        chk("t5_rst_data", ram_write_data, 128'h0);
        tick();
        rst = 1'b0;
        ram_write_rdy = 1'b1;
        repeat (3) tick();
        chk("t5_no_writes_after_rst", lg_addr.size(), 2);
        clear_logs();
        cmd(8'h80, 4'd2, 1'b0, 4'd0, 4'd15);
        stream(3, 32'h0000_7000);
        wait_idle(30);
        chk("t5_new_writes", lg_addr.size(), 3);
        for (int k = 0; k < 3 && k < lg_addr.size(); k++) begin
            chk("t5_new_addr", lg_addr[k], 8'(8'h80 + k));
        end
        chk("t5_done_pulses", lg_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
